// File: rtl/multicycle_controller.sv
// Five-phase multicycle control unit: run/stop sequencing, IR, registered decode, flags, branch resolve.
// Latency: 5 cycles per instruction; P1 starts one cycle after a rising edge on exec.
// Backpressure: none; an exec edge while running stops after the current instruction completes.
module multicycle_controller #(
    parameter int INSTR_W     = 16,
    parameter bit SINGLE_STEP = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec,
    input  logic [INSTR_W-1:0] instr,
    input  logic [3:0]         alu_flags,
    output logic [4:0]         phase,
    output logic               running,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               ALUSrc,
    output logic               MemWrite,
    output logic               FlagWrite,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               Halt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_P1     = 3'd1,
        S_P2     = 3'd2,
        S_P3     = 3'd3,
        S_P4     = 3'd4,
        S_P5     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [3:0]         flags_q, flags_d;
    logic               exec_q, exec_d;
    logic               stop_req_q, stop_req_d;

    // Registered outputs, computed from the next state so they line up with the phase they belong to
    logic [4:0] phase_q, phase_d;
    logic       running_q, running_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       reg_dst_q, reg_dst_d;
    logic       alu_src_q, alu_src_d;
    logic       mem_write_q, mem_write_d;
    logic       flag_write_q, flag_write_d;
    logic       pc_write_q, pc_write_d;
    logic       pc_src_q, pc_src_d;
    logic       halt_q, halt_d;

    logic       exec_edge;
    logic [1:0] op1;
    logic [2:0] op2;
    logic [2:0] cond;
    logic [3:0] op3;
    logic       is_ld, is_st, is_li, is_alu, is_hlt, no_wb;
    logic       wr_reg, wr_flags, is_b, is_bcc, cond_true, taken;
    logic       ctl_phase, br_phase;

    assign exec_edge = exec & ~exec_q;

    // Instruction register captures memory data at the end of P1 and holds it otherwise
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_P1) begin
            ir_d = instr;
        end
    end

    // Field extraction from the (next) instruction register; equals ir_q from P2 onward
    assign op1  = ir_d[INSTR_W-1 -: 2];
    assign op2  = ir_d[INSTR_W-3 -: 3];
    assign cond = ir_d[INSTR_W-6 -: 3];
    assign op3  = ir_d[7:4];

    assign is_ld    = (op1 == 2'b00);
    assign is_st    = (op1 == 2'b01);
    assign is_li    = (op1 == 2'b10) && (op2 == 3'b000);
    assign is_alu   = (op1 == 2'b11);
    assign is_hlt   = is_alu && (op3 == 4'b1111);
    // CMP, OUT, NOP and HLT produce no register result
    assign no_wb    = (op3 == 4'b0101) || (op3 == 4'b1101) || (op3 == 4'b1110) || (op3 == 4'b1111);
    assign wr_reg   = is_ld || is_li || (is_alu && !no_wb);
    assign wr_flags = is_alu && (op3 <= 4'd6);
    assign is_b     = (op1 == 2'b10) && (op2 == 3'b100);
    assign is_bcc   = (op1 == 2'b10) && (op2 == 3'b111);
    assign taken    = is_b || (is_bcc && cond_true);

    // Conditional branch evaluation against the stored {S,Z,C,V} flags
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = flags_q[2];
            3'b001:  cond_true = flags_q[3] ^ flags_q[0];
            3'b010:  cond_true = flags_q[2] | (flags_q[3] ^ flags_q[0]);
            3'b011:  cond_true = ~flags_q[2];
            default: cond_true = 1'b0;
        endcase
    end

    // Phase sequencing, stop request capture and flag register update
    always_comb begin
        state_d    = state_q;
        stop_req_d = stop_req_q;
        flags_d    = flags_q;
        exec_d     = exec;
        case (state_q)
            S_IDLE: begin
                if (exec_edge) state_d = S_P1;
            end
            S_P1: begin
                state_d = S_P2;
                if (exec_edge) stop_req_d = 1'b1;
            end
            S_P2: begin
                state_d = S_P3;
                if (exec_edge) stop_req_d = 1'b1;
            end
            S_P3: begin
                state_d = S_P4;
                if (wr_flags) flags_d = alu_flags;
                if (exec_edge) stop_req_d = 1'b1;
            end
            S_P4: begin
                state_d = S_P5;
                if (exec_edge) stop_req_d = 1'b1;
            end
            S_P5: begin
                // HLT wins over any pending or same-cycle stop request
                stop_req_d = 1'b0;
                if (is_hlt) begin
                    state_d = S_HALTED;
                end else if (stop_req_q || exec_edge || SINGLE_STEP) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_P1;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d    = S_IDLE;
                stop_req_d = 1'b0;
            end
        endcase
    end

    assign ctl_phase = (state_d == S_P2) || (state_d == S_P3) || (state_d == S_P4) || (state_d == S_P5);
    assign br_phase  = (state_d == S_P3) || (state_d == S_P4) || (state_d == S_P5);

    // Next values of the datapath controls for the phase being entered
    always_comb begin
        phase_d = 5'b00000;
        case (state_d)
            S_P1:    phase_d = 5'b00001;
            S_P2:    phase_d = 5'b00010;
            S_P3:    phase_d = 5'b00100;
            S_P4:    phase_d = 5'b01000;
            S_P5:    phase_d = 5'b10000;
            default: phase_d = 5'b00000;
        endcase
        running_d    = (state_d == S_P1) || ctl_phase;
        mem_to_reg_d = ctl_phase && is_ld;
        reg_dst_d    = ctl_phase && !is_ld;
        alu_src_d    = ctl_phase && (is_ld || is_st);
        reg_write_d  = (state_d == S_P5) && wr_reg;
        mem_write_d  = (state_d == S_P4) && is_st;
        flag_write_d = (state_d == S_P3) && wr_flags;
        pc_write_d   = (state_d == S_P5) && !is_hlt;
        pc_src_d     = br_phase && taken;
        halt_d       = (state_d == S_HALTED);
    end

    // All state and output flops; reset clears everything at once so no enable can stay high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ir_q         <= '0;
            flags_q      <= 4'b0000;
            exec_q       <= 1'b0;
            stop_req_q   <= 1'b0;
            phase_q      <= 5'b00000;
            running_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            flag_write_q <= 1'b0;
            pc_write_q   <= 1'b0;
            pc_src_q     <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            flags_q      <= flags_d;
            exec_q       <= exec_d;
            stop_req_q   <= stop_req_d;
            phase_q      <= phase_d;
            running_q    <= running_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_dst_q    <= reg_dst_d;
            alu_src_q    <= alu_src_d;
            mem_write_q  <= mem_write_d;
            flag_write_q <= flag_write_d;
            pc_write_q   <= pc_write_d;
            pc_src_q     <= pc_src_d;
            halt_q       <= halt_d;
        end
    end

    assign phase     = phase_q;
    assign running   = running_q;
    assign RegWrite  = reg_write_q;
    assign MemtoReg  = mem_to_reg_q;
    assign RegDst    = reg_dst_q;
    assign ALUSrc    = alu_src_q;
    assign MemWrite  = mem_write_q;
    assign FlagWrite = flag_write_q;
    assign PCWrite   = pc_write_q;
    assign PCSrc     = pc_src_q;
    assign Halt      = halt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: scoreboarded per-phase control vectors from a per-instruction model.
// Latency: expected vectors queued at run start, popped each cycle the DUT reports running.
// Backpressure: none; waits on DUT phases are bounded and report a failure on timeout.
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exec = 1'b0;
    logic        exec_s = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [15:0] instr_s = 16'h0000;
    logic [3:0]  alu_flags = 4'b0000;

    logic [4:0] phase, ss_phase;
    logic running, RegWrite, MemtoReg, RegDst, ALUSrc, MemWrite, FlagWrite, PCWrite, PCSrc, Halt;
    logic ss_running, ss_RegWrite, ss_MemtoReg, ss_RegDst, ss_ALUSrc, ss_MemWrite;
    logic ss_FlagWrite, ss_PCWrite, ss_PCSrc, ss_Halt;

    logic [14:0] obs, obs_s;
    assign obs   = {phase, running, RegWrite, MemtoReg, RegDst, ALUSrc, MemWrite, FlagWrite,
                    PCWrite, PCSrc, Halt};
    assign obs_s = {ss_phase, ss_running, ss_RegWrite, ss_MemtoReg, ss_RegDst, ss_ALUSrc,
                    ss_MemWrite, ss_FlagWrite, ss_PCWrite, ss_PCSrc, ss_Halt};

    always #5 clock = ~clock;

    multicycle_controller #(.INSTR_W(16), .SINGLE_STEP(1'b0)) dut (
        .clock(clock), .reset(reset), .exec(exec), .instr(instr), .alu_flags(alu_flags),
        .phase(phase), .running(running), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .FlagWrite(FlagWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Halt(Halt)
    );

    multicycle_controller #(.INSTR_W(16), .SINGLE_STEP(1'b1)) dut_ss (
        .clock(clock), .reset(reset), .exec(exec_s), .instr(instr_s), .alu_flags(alu_flags),
        .phase(ss_phase), .running(ss_running), .RegWrite(ss_RegWrite), .MemtoReg(ss_MemtoReg),
        .RegDst(ss_RegDst), .ALUSrc(ss_ALUSrc), .MemWrite(ss_MemWrite), .FlagWrite(ss_FlagWrite),
        .PCWrite(ss_PCWrite), .PCSrc(ss_PCSrc), .Halt(ss_Halt)
    );

    int          checks = 0;
    int          errors = 0;
    logic [14:0] exp_q[$];
    logic [15:0] prog[$];
    logic [3:0]  pfl[$];
    logic [3:0]  mflags = 4'b0000;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: expected control vector of one instruction in phase p (1..5), given stored flags
    function automatic logic [14:0] model(input logic [15:0] ins, input int p, input logic [3:0] fl);
        logic [1:0]  o1;
        logic [2:0]  o2, cd;
        logic [3:0]  o3;
        logic        ld, st, li, alu, hlt, wb, br, s, z, v;
        logic [14:0] vec;
        o1 = ins[15:14]; o2 = ins[13:11]; cd = ins[10:8]; o3 = ins[7:4];
        s = fl[3]; z = fl[2]; v = fl[0];
        ld  = (o1 == 2'd0);
        st  = (o1 == 2'd1);
        li  = (o1 == 2'd2) && (o2 == 3'd0);
        alu = (o1 == 2'd3);
        hlt = alu && (o3 == 4'd15);
        wb  = ld || li || (alu && o3 != 4'd5 && o3 != 4'd13 && o3 != 4'd14 && o3 != 4'd15);
        br  = 1'b0;
        if (o1 == 2'd2 && o2 == 3'd4) br = 1'b1;
        if (o1 == 2'd2 && o2 == 3'd7) begin
            case (cd)
                3'd0:    br = z;
                3'd1:    br = s ^ v;
                3'd2:    br = z | (s ^ v);
                3'd3:    br = !z;
                default: br = 1'b0;
            endcase
        end
        vec        = '0;
        vec[14:10] = 5'(1 << (p - 1));
        vec[9]     = 1'b1;
        vec[8]     = (p == 5) && wb;
        vec[7]     = (p >= 2) && ld;
        vec[6]     = (p >= 2) && !ld;
        vec[5]     = (p >= 2) && (ld || st);
        vec[4]     = (p == 4) && st;
        vec[3]     = (p == 3) && alu && (o3 <= 4'd6);
        vec[2]     = (p == 5) && !hlt;
        vec[1]     = (p >= 3) && br;
        vec[0]     = 1'b0;
        return vec;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 5))
            0: w[15:14] = 2'b00;
            1: w[15:14] = 2'b01;
            2: w[15:14] = 2'b10;
            3: w[15:11] = 5'b10111;
            4: w[15:11] = 5'b10100;
            default: begin
                w[15:14] = 2'b11;
                if (w[7:4] == 4'hF) w[7:4] = 4'h0;
            end
        endcase
        return w;
    endfunction

    task automatic add(input logic [15:0] w, input logic [3:0] f);
        prog.push_back(w);
        pfl.push_back(f);
    endtask

    task automatic pulse_exec();
        @(negedge clock); exec = 1'b1;
        @(negedge clock); exec = 1'b0;
    endtask

    // Monitor: every cycle the DUT reports running, pop and compare one expected vector
    initial begin
        logic [14:0] e;
        forever begin
            @(negedge clock); #1;
            if (running === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_phase actual=%h required=none at %0t", obs, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("phase_vector", 32'(obs), 32'(e));
                end
            end
        end
    end

    // Queue the whole program's expectations, start it, feed instr/flags at each P1.
    // stop_ph>0 raises exec that many cycles into P1 of the last instruction.
    task automatic run_prog(input int stop_ph);
        int          n;
        int          k;
        logic [14:0] v;
        n = prog.size();
        for (int i = 0; i < n; i++) begin
            for (int p = 1; p <= 5; p++) begin
                v = model(prog[i], p, mflags);
                exp_q.push_back(v);
                if (p == 3 && v[3]) mflags = pfl[i];
            end
        end
        pulse_exec();
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (phase !== 5'b00001 && k < 20) begin
                @(negedge clock);
                k++;
            end
            if (k >= 20) begin
                checks++;
                errors++;
                $display("FAIL p1_timeout instr=%0d actual=%b required=00001", i, phase);
                exp_q.delete();
                return;
            end
            instr     = prog[i];
            alu_flags = pfl[i];
            if (i == n - 1 && stop_ph > 0) begin
                repeat (stop_ph) @(negedge clock);
                exec = 1'b1;
                @(negedge clock);
                exec = 1'b0;
            end
            @(negedge clock);
        end
        repeat (10) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        int pcw;
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'(obs), 32'd0);
        check("reset_outputs_ss", 32'(obs_s), 32'd0);
        reset  = 1'b1;
        mflags = 4'b0000;
        repeat (2) @(negedge clock);
        check("idle_no_exec", 32'(obs), 32'd0);

        // Directed program: ALU op, compares feeding every branch condition, memory ops, stop in P3
        prog.delete(); pfl.delete();
        add(16'hC000, 4'($urandom)); add(16'hC050, 4'b0100);
        add(16'hB812, 4'($urandom)); add(16'hBB34, 4'($urandom));
        add(16'hC050, 4'b1000);      add(16'hB900, 4'($urandom));
        add(16'hC050, 4'b1001);      add(16'hB900, 4'($urandom)); add(16'hBA00, 4'($urandom));
        add(16'hC050, 4'b1101);      add(16'hBA00, 4'($urandom));
        add(16'h4567, 4'($urandom)); add(16'h0123, 4'($urandom));
        add(16'h8000, 4'($urandom)); add(16'hA000, 4'($urandom));
        add(16'hC000, 4'($urandom));
        run_prog(2);
        check("stopped_idle", 32'(obs), 32'd0);

        // Random programs, each stopped by exec during P2..P4 of its last instruction
        for (int r = 0; r < 3; r++) begin
            prog.delete(); pfl.delete();
            for (int j = 0; j < int'($urandom_range(4, 10)); j++) add(rand_instr(), 4'($urandom));
            run_prog(int'($urandom_range(1, 3)));
            check("random_stop_idle", 32'(obs), 32'd0);
        end

        // Program ending in HLT: sticky halt, exec ignored
        prog.delete(); pfl.delete();
        for (int j = 0; j < 5; j++) add(rand_instr(), 4'($urandom));
        add(16'hC0F0, 4'($urandom));
        run_prog(0);
        check("halted", 32'(obs), 32'h0001);
        pulse_exec();
        repeat (4) @(negedge clock);
        pulse_exec();
        repeat (8) @(negedge clock);
        check("halted_sticky", 32'(obs), 32'h0001);

        reset = 1'b0;
        @(negedge clock);
        reset  = 1'b1;
        mflags = 4'b0000;
        @(negedge clock);
        check("halt_cleared", 32'(obs), 32'd0);

        // Asynchronous reset in P4 of a store
        for (int p = 1; p <= 4; p++) exp_q.push_back(model(16'h4123, p, mflags));
        pulse_exec();
        instr = 16'h4123;
        repeat (3) @(negedge clock);
        #2;
        check("st_p4_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        #3;
        reset  = 1'b1;
        mflags = 4'b0000;
        repeat (3) @(negedge clock);
        check("idle_after_reset", 32'(obs), 32'd0);
        check("reset_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Flags cleared by reset: BNE taken, BE not taken
        prog.delete(); pfl.delete();
        add(16'hBB00, 4'b0100); add(16'hB800, 4'b0100);
        run_prog(1);
        check("flags_reset_idle", 32'(obs), 32'd0);

        // Single-step instance: one instruction per exec pulse
        for (int t = 0; t < 4; t++) begin
            instr_s = rand_instr();
            cnt = 0;
            pcw = 0;
            @(negedge clock); exec_s = 1'b1;
            @(negedge clock); exec_s = 1'b0;
            for (int c = 0; c < 12; c++) begin
                if (ss_running) cnt++;
                if (ss_PCWrite) pcw++;
                @(negedge clock);
            end
            check("ss_cycles", 32'(cnt), 32'd5);
            check("ss_pcwrite", 32'(pcw), 32'd1);
            check("ss_idle", 32'(obs_s), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
